pu_msp430_mpy_sequencer: RTL and testbench
==========================================

// Module: pu_msp430_mpy_sequencer
// PURPOSE
// - Peripheral-bus initiator for the hardware multiplier: takes one command (mode, OP1, OP2), issues the
//   MSP430 peripheral write/read sequence and returns the 32-bit result plus SUMEXT.
// - Sits between an accelerator/DMA client and the per_* bus; offloads MPY/MAC sequencing from the CPU.
// PARAMETERS
// - BASE_ADDR  15'h0130  multiplier byte base address; word address = BASE_ADDR[14:1] + reg_offset/2
// - WAIT_CYC   1         idle bus cycles between OP2 write and RESLO read; legal 1..3
// PORTS
// - mclk_op1     in   1   clock
// - puc_rst      in   1   reset, asynchronous, active-high
// - cmd_valid    in   1   command request
// - cmd_ready    out  1   high only in IDLE
// - cmd_mode     in   2   00 MPY, 01 MPYS, 10 MAC, 11 MACS
// - cmd_clr      in   1   zero RESLO/RESHI before OP1 write (used for MAC/MACS chains)
// - cmd_op1      in   16  first operand
// - cmd_op2      in   16  second operand
// - rsp_valid    out  1   result available; held until rsp_ready
// - rsp_ready    in   1   result consumed
// - rsp_lo       out  16  RESLO
// - rsp_hi       out  16  RESHI
// - rsp_sumext   out  16  SUMEXT
// - per_addr     out  14  peripheral word address
// - per_din      out  16  peripheral write data
// - per_en       out  1   peripheral enable
// - per_we       out  2   byte write enables
// - per_dout     in   16  peripheral read data, combinational in the access cycle
// BEHAVIOUR
// - Reset: state IDLE; cmd_ready=1; rsp_valid=0; rsp_* =0; per_en=0, per_we=0, per_addr=0, per_din=0.
// - Accept on edge where cmd_valid&cmd_ready; cmd_* captured in registers; the bus is driven from the
//   state and the captured registers only, never combinationally from cmd_*.
// - FSM: IDLE -> [CLR_LO -> CLR_HI if cmd_clr] -> WR_OP1 -> WR_OP2 -> WAIT(xWAIT_CYC) -> RD_LO -> RD_HI
//   -> [RD_EXT] -> RESP -> IDLE (on rsp_ready). Each non-IDLE/RESP state lasts exactly one cycle,
//   except WAIT, which lasts WAIT_CYC cycles (down-counter).
// - Write states: per_en=1, per_we=2'b11. CLR_*: per_din=0. WR_OP1: per_din=op1. WR_OP2: per_din=op2.
// - WR_OP1 word address by mode: MPY 0x098, MPYS 0x099, MAC 0x09A, MACS 0x09B (default BASE_ADDR).
// - Other word addresses: OP2 0x09C, RESLO 0x09D, RESHI 0x09E, SUMEXT 0x09F.
// - Read states: per_en=1, per_we=0; per_dout sampled into rsp_lo, rsp_hi or rsp_sumext on the edge
//   that ends the state.
// - All other states: per_en=0, per_we=0, per_addr=0, per_din=0. No back-to-back bus gaps except WAIT.
// - Latency (WAIT_CYC=1, no clr, SUMEXT_EN defined): accept edge E; WR_OP1 in cycle E+1; rsp_valid=1
//   from E+7. Each clr adds 2 cycles; each extra WAIT_CYC adds 1; no SUMEXT_EN subtracts 1.
// - RESP: rsp_* stable while rsp_valid & ~rsp_ready; return to IDLE on the edge with rsp_ready=1.
//   cmd_ready rises the next cycle, so there are no same-cycle accept/complete overlaps.
// - cmd_valid outside IDLE is ignored, not queued.
// - Reset mid-operation: immediate return to the reset state and bus released.
//   Multiplier contents are undefined to the client afterwards.
// - WAIT_CYC>=1 is required: a 16x16 multiplier updates RESLO one cycle after the OP2 write;
//   a 16x8 multiplier relies on its early-read path.
// CONFIGURATION
// - MPY_SEQ_SUMEXT_EN defined: RD_EXT state present; rsp_sumext = SUMEXT read value.
// - MPY_SEQ_SUMEXT_EN undefined: no RD_EXT state; rsp_sumext tied to 16'h0000; latency 1 cycle shorter.
// TESTING
// - MPY 0x1234*0x0010 -> rsp_lo=0x2340, rsp_hi=0x0001, rsp_sumext=0x0000.
//   Bus trace: writes 0x098, 0x09C; reads 0x09D, 0x09E, 0x09F.
// - MPYS 0xFFFF*0x0002 -> lo=0xFFFE, hi=0xFFFF, sumext=0xFFFF. WR_OP1 targets 0x099.
// - MAC+clr 0xFFFF*0xFFFF -> lo=0x0001, hi=0xFFFE, sumext=0.
//   Repeat without clr -> lo=0x0002, hi=0xFFFC, sumext=0x0001.
// - Timing: with WAIT_CYC=1, accept at E gives rsp_valid at E+7 (E+9 with clr).
//   With WAIT_CYC=3 the RESLO read comes 2 cycles later. Check per_en=0 in every WAIT cycle.
// - Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_* stable, cmd_ready=0.
//   A cmd_valid pulse during this time is not accepted.
// - Assert puc_rst during WR_OP2 -> next edge: per_en=0, rsp_valid=0, cmd_ready=1.
//   A new MPY 3*5 then returns lo=0x000F.

Source files
------------

// File: rtl/pu_msp430_mpy_sequencer.sv
// Peripheral-bus initiator that runs one MPY/MPYS/MAC/MACS command on the MSP430 hardware multiplier.
// Optional SUMEXT readback is enabled by defining MPY_SEQ_SUMEXT_EN.
module pu_msp430_mpy_sequencer #(
  parameter logic [14:0] BASE_ADDR = 15'h0130,
  parameter int unsigned WAIT_CYC  = 1
) (
  input  logic        mclk_op1,
  input  logic        puc_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_mode,
  input  logic        cmd_clr,
  input  logic [15:0] cmd_op1,
  input  logic [15:0] cmd_op2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_lo,
  output logic [15:0] rsp_hi,
  output logic [15:0] rsp_sumext,
  output logic [13:0] per_addr,
  output logic [15:0] per_din,
  output logic        per_en,
  output logic [1:0]  per_we,
  input  logic [15:0] per_dout
);

  localparam int unsigned AW     = 14;
  localparam int unsigned DW     = 16;
  localparam int unsigned WAIT_W = 2;

  localparam logic [AW-1:0]     BASE_WORD  = BASE_ADDR[14:1];
  localparam logic [AW-1:0]     OFS_OP2    = AW'(4);
  localparam logic [AW-1:0]     OFS_RESLO  = AW'(5);
  localparam logic [AW-1:0]     OFS_RESHI  = AW'(6);
  localparam logic [AW-1:0]     OFS_SUMEXT = AW'(7);
  localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(WAIT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR_LO,
    S_CLR_HI,
    S_WR_OP1,
    S_WR_OP2,
    S_WAIT,
    S_RD_LO,
    S_RD_HI,
    S_RD_EXT,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [1:0]        r_mode;
  logic [1:0]        w_mode_nxt;
  logic [DW-1:0]     r_op1;
  logic [DW-1:0]     w_op1_nxt;
  logic [DW-1:0]     r_op2;
  logic [DW-1:0]     w_op2_nxt;

  logic              r_cmd_ready;
  logic              w_cmd_ready_nxt;
  logic              r_rsp_valid;
  logic              w_rsp_valid_nxt;
  logic [DW-1:0]     r_rsp_lo;
  logic [DW-1:0]     w_rsp_lo_nxt;
  logic [DW-1:0]     r_rsp_hi;
  logic [DW-1:0]     w_rsp_hi_nxt;
`ifdef MPY_SEQ_SUMEXT_EN
  logic [DW-1:0]     r_rsp_ext;
  logic [DW-1:0]     w_rsp_ext_nxt;
`endif

  logic              r_per_en;
  logic              w_per_en_nxt;
  logic [1:0]        r_per_we;
  logic [1:0]        w_per_we_nxt;
  logic [AW-1:0]     r_per_addr;
  logic [AW-1:0]     w_per_addr_nxt;
  logic [DW-1:0]     r_per_din;
  logic [DW-1:0]     w_per_din_nxt;

  // Next-state, capture and read-sampling logic; bus outputs are decoded from the next state so
  // the registered bus lines up exactly with the state that owns the access.
  always_comb begin
    w_state_nxt     = r_state;
    w_wait_nxt      = r_wait_cnt;
    w_mode_nxt      = r_mode;
    w_op1_nxt       = r_op1;
    w_op2_nxt       = r_op2;
    w_rsp_lo_nxt    = r_rsp_lo;
    w_rsp_hi_nxt    = r_rsp_hi;
`ifdef MPY_SEQ_SUMEXT_EN
    w_rsp_ext_nxt   = r_rsp_ext;
`endif
    w_per_en_nxt    = 1'b0;
    w_per_we_nxt    = 2'b00;
    w_per_addr_nxt  = '0;
    w_per_din_nxt   = '0;
    w_cmd_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_mode_nxt  = cmd_mode;
          w_op1_nxt   = cmd_op1;
          w_op2_nxt   = cmd_op2;
          w_state_nxt = cmd_clr ? S_CLR_LO : S_WR_OP1;
        end
      end
      S_CLR_LO: w_state_nxt = S_CLR_HI;
      S_CLR_HI: w_state_nxt = S_WR_OP1;
      S_WR_OP1: w_state_nxt = S_WR_OP2;
      S_WR_OP2: begin
        w_wait_nxt  = WAIT_LOAD;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_nxt = S_RD_LO;
        end else begin
          w_wait_nxt = r_wait_cnt - WAIT_W'(1);
        end
      end
      S_RD_LO: begin
        w_rsp_lo_nxt = per_dout;
        w_state_nxt  = S_RD_HI;
      end
      S_RD_HI: begin
        w_rsp_hi_nxt = per_dout;
`ifdef MPY_SEQ_SUMEXT_EN
        w_state_nxt  = S_RD_EXT;
`else
        w_state_nxt  = S_RESP;
`endif
      end
`ifdef MPY_SEQ_SUMEXT_EN
      S_RD_EXT: begin
        w_rsp_ext_nxt = per_dout;
        w_state_nxt   = S_RESP;
      end
`endif
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Bus decode for the state entered on the coming edge
    case (w_state_nxt)
      S_CLR_LO: begin
        w_per_en_nxt   = 1'b1;
        w_per_we_nxt   = 2'b11;
        w_per_addr_nxt = BASE_WORD + OFS_RESLO;
      end
      S_CLR_HI: begin
        w_per_en_nxt   = 1'b1;
        w_per_we_nxt   = 2'b11;
        w_per_addr_nxt = BASE_WORD + OFS_RESHI;
      end
      S_WR_OP1: begin
        w_per_en_nxt   = 1'b1;
        w_per_we_nxt   = 2'b11;
        w_per_addr_nxt = BASE_WORD + AW'(w_mode_nxt);
        w_per_din_nxt  = w_op1_nxt;
      end
      S_WR_OP2: begin
        w_per_en_nxt   = 1'b1;
        w_per_we_nxt   = 2'b11;
        w_per_addr_nxt = BASE_WORD + OFS_OP2;
        w_per_din_nxt  = w_op2_nxt;
      end
      S_RD_LO: begin
        w_per_en_nxt   = 1'b1;
        w_per_addr_nxt = BASE_WORD + OFS_RESLO;
      end
      S_RD_HI: begin
        w_per_en_nxt   = 1'b1;
        w_per_addr_nxt = BASE_WORD + OFS_RESHI;
      end
      S_RD_EXT: begin
        w_per_en_nxt   = 1'b1;
        w_per_addr_nxt = BASE_WORD + OFS_SUMEXT;
      end
      default: begin
        w_per_en_nxt   = 1'b0;
      end
    endcase

    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_rsp_valid_nxt = (w_state_nxt == S_RESP);
  end

  // State, captured command and registered outputs
  always_ff @(posedge mclk_op1 or posedge puc_rst) begin
    if (puc_rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_mode      <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_lo    <= '0;
      r_rsp_hi    <= '0;
`ifdef MPY_SEQ_SUMEXT_EN
      r_rsp_ext   <= '0;
`endif
      r_per_en    <= 1'b0;
      r_per_we    <= 2'b00;
      r_per_addr  <= '0;
      r_per_din   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_mode      <= w_mode_nxt;
      r_op1       <= w_op1_nxt;
      r_op2       <= w_op2_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_lo    <= w_rsp_lo_nxt;
      r_rsp_hi    <= w_rsp_hi_nxt;
`ifdef MPY_SEQ_SUMEXT_EN
      r_rsp_ext   <= w_rsp_ext_nxt;
`endif
      r_per_en    <= w_per_en_nxt;
      r_per_we    <= w_per_we_nxt;
      r_per_addr  <= w_per_addr_nxt;
      r_per_din   <= w_per_din_nxt;
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_lo     = r_rsp_lo;
  assign rsp_hi     = r_rsp_hi;
`ifdef MPY_SEQ_SUMEXT_EN
  assign rsp_sumext = r_rsp_ext;
`else
  assign rsp_sumext = 16'h0000;
`endif
  assign per_en     = r_per_en;
  assign per_we     = r_per_we;
  assign per_addr   = r_per_addr;
  assign per_din    = r_per_din;

endmodule

// File: tb/tb_pu_msp430_mpy_sequencer.sv
// Directed bench for pu_msp430_mpy_sequencer: behavioural multiplier on the bus of the default
// instance, plus a WAIT_CYC=3 instance answering reads with an address-derived pattern.
module tb_pu_msp430_mpy_sequencer;

`ifdef MPY_SEQ_SUMEXT_EN
  localparam bit EXT_ON = 1'b1;
`else
  localparam bit EXT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        puc_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_valid3 = 1'b0;
  logic [1:0]  cmd_mode = 2'b00;
  logic        cmd_clr = 1'b0;
  logic [15:0] cmd_op1 = 16'h0;
  logic [15:0] cmd_op2 = 16'h0;
  logic        rsp_ready = 1'b0;
  logic        rsp_ready3 = 1'b0;

  logic        cmd_ready, rsp_valid, per_en;
  logic [15:0] rsp_lo, rsp_hi, rsp_sumext, per_din, per_dout;
  logic [13:0] per_addr;
  logic [1:0]  per_we;

  logic        cmd_ready3, rsp_valid3, per_en3;
  logic [15:0] rsp_lo3, rsp_hi3, rsp_sumext3, per_din3, per_dout3;
  logic [13:0] per_addr3;
  logic [1:0]  per_we3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pu_msp430_mpy_sequencer u_dut (
    .mclk_op1(clk), .puc_rst(puc_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_clr(cmd_clr),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
    .rsp_sumext(rsp_sumext),
    .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we), .per_dout(per_dout)
  );

  pu_msp430_mpy_sequencer #(.WAIT_CYC(3)) u_dut3 (
    .mclk_op1(clk), .puc_rst(puc_rst),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_mode(cmd_mode), .cmd_clr(cmd_clr),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_lo(rsp_lo3), .rsp_hi(rsp_hi3),
    .rsp_sumext(rsp_sumext3),
    .per_addr(per_addr3), .per_din(per_din3), .per_en(per_en3), .per_we(per_we3),
    .per_dout(per_dout3)
  );

  // Multiplier model: result registers update one cycle after the OP2 write
  logic [15:0] m_op1 = 16'h0, m_op2 = 16'h0, m_lo = 16'h0, m_hi = 16'h0, m_ext = 16'h0;
  logic [1:0]  m_mode = 2'b00;
  logic        m_pend = 1'b0;
  logic [31:0] m_a, m_b, m_p;
  logic [32:0] m_acc;
  logic [15:0] m_ext_nxt;

  always_comb begin
    m_a   = m_mode[0] ? {{16{m_op1[15]}}, m_op1} : {16'h0, m_op1};
    m_b   = m_mode[0] ? {{16{m_op2[15]}}, m_op2} : {16'h0, m_op2};
    m_p   = m_a * m_b;
    m_acc = m_mode[1] ? ({1'b0, m_hi, m_lo} + {1'b0, m_p}) : {1'b0, m_p};
    case (m_mode)
      2'b00:   m_ext_nxt = 16'h0000;
      2'b10:   m_ext_nxt = {15'h0, m_acc[32]};
      default: m_ext_nxt = m_acc[31] ? 16'hFFFF : 16'h0000;
    endcase
  end

  always @(posedge clk) begin
    if (m_pend) begin
      m_pend <= 1'b0;
      m_lo   <= m_acc[15:0];
      m_hi   <= m_acc[31:16];
      m_ext  <= m_ext_nxt;
    end
    if (per_en && per_we == 2'b11) begin
      case (per_addr)
        14'h098, 14'h099, 14'h09A, 14'h09B: begin
          m_op1  <= per_din;
          m_mode <= per_addr[1:0];
        end
        14'h09C: begin
          m_op2  <= per_din;
          m_pend <= 1'b1;
        end
        14'h09D: m_lo <= per_din;
        14'h09E: m_hi <= per_din;
        default: ;
      endcase
    end
  end

  always_comb begin
    per_dout = 16'h0;
    if (per_en && per_we == 2'b00) begin
      case (per_addr)
        14'h09D: per_dout = m_lo;
        14'h09E: per_dout = m_hi;
        14'h09F: per_dout = m_ext;
        default: per_dout = 16'h0;
      endcase
    end
  end

  assign per_dout3 = (per_en3 && per_we3 == 2'b00) ? {2'b10, per_addr3} : 16'h0;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] mode, input logic clr,
                      input logic [15:0] op1, input logic [15:0] op2);
    chk("send.cmd_ready", 64'(cmd_ready), 64'(1'b1));
    cmd_mode  = mode;
    cmd_clr   = clr;
    cmd_op1   = op1;
    cmd_op2   = op2;
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
  endtask

  // Walks one command cycle by cycle from the accept edge up to RESP
  task automatic txn(input string tag, input logic [1:0] mode, input logic clr,
                     input logic [15:0] op1, input logic [15:0] op2,
                     input logic [15:0] exp_lo, input logic [15:0] exp_hi,
                     input logic [15:0] exp_ext);
    logic [13:0] a1;
    a1 = 14'h098 + 14'(mode);
    send(mode, clr, op1, op2);
    if (clr) begin
      chk({tag, ".clr_lo"}, 64'({per_en, per_we, per_addr, per_din}), 64'({1'b1, 2'b11, 14'h09D, 16'h0}));
      cycle();
      chk({tag, ".clr_hi"}, 64'({per_en, per_we, per_addr, per_din}), 64'({1'b1, 2'b11, 14'h09E, 16'h0}));
      cycle();
    end
    chk({tag, ".wr_op1"}, 64'({per_en, per_we, per_addr, per_din}), 64'({1'b1, 2'b11, a1, op1}));
    cycle();
    chk({tag, ".wr_op2"}, 64'({per_en, per_we, per_addr, per_din}), 64'({1'b1, 2'b11, 14'h09C, op2}));
    cycle();
    chk({tag, ".wait"}, 64'({rsp_valid, cmd_ready, per_en, per_we, per_addr, per_din}), 64'(0));
    cycle();
    chk({tag, ".rd_lo"}, 64'({rsp_valid, per_en, per_we, per_addr}), 64'({1'b0, 1'b1, 2'b00, 14'h09D}));
    cycle();
    chk({tag, ".rd_hi"}, 64'({rsp_valid, per_en, per_we, per_addr}), 64'({1'b0, 1'b1, 2'b00, 14'h09E}));
    cycle();
`ifdef MPY_SEQ_SUMEXT_EN
    chk({tag, ".rd_ext"}, 64'({rsp_valid, per_en, per_we, per_addr}), 64'({1'b0, 1'b1, 2'b00, 14'h09F}));
    cycle();
`endif
    chk({tag, ".resp"}, 64'({cmd_ready, rsp_valid, per_en}), 64'(3'b010));
    chk({tag, ".lo_hi"}, 64'({rsp_lo, rsp_hi}), 64'({exp_lo, exp_hi}));
    chk({tag, ".sumext"}, 64'(rsp_sumext), 64'(EXT_ON ? exp_ext : 16'h0000));
  endtask

  task automatic release_rsp(input string tag);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    chk({tag, ".release"}, 64'({cmd_ready, rsp_valid, per_en}), 64'(3'b100));
  endtask

  initial begin
    // Reset state
    cycle();
    cycle();
    chk("rst.ready_valid", 64'({cmd_ready, rsp_valid, cmd_ready3, rsp_valid3}), 64'(4'b1010));
    chk("rst.bus", 64'({per_en, per_we, per_addr, per_din}), 64'(0));
    chk("rst.rsp", 64'({rsp_lo, rsp_hi, rsp_sumext}), 64'(0));
    puc_rst = 1'b0;
    cycle();

    txn("mpy", 2'b00, 1'b0, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 16'h0000);
    release_rsp("mpy");
    txn("mpys", 2'b01, 1'b0, 16'hFFFF, 16'h0002, 16'hFFFE, 16'hFFFF, 16'hFFFF);
    release_rsp("mpys");
    txn("mac_clr", 2'b10, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 16'h0000);
    release_rsp("mac_clr");
    txn("mac_acc", 2'b10, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0002, 16'hFFFC, 16'h0001);
    release_rsp("mac_acc");

    // Backpressure: response held for 10 cycles, a stray command pulse is dropped
    txn("macs", 2'b11, 1'b1, 16'hFFFE, 16'h0003, 16'hFFFA, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        cmd_mode  = 2'b00;
        cmd_clr   = 1'b0;
        cmd_op1   = 16'h0001;
        cmd_op2   = 16'h0001;
        cmd_valid = 1'b1;
      end
      cycle();
      cmd_valid = 1'b0;
      chk("bp.ctrl", 64'({cmd_ready, rsp_valid, per_en}), 64'(3'b010));
      chk("bp.data", 64'({rsp_lo, rsp_hi, rsp_sumext}),
          64'({16'hFFFA, 16'hFFFF, (EXT_ON ? 16'hFFFF : 16'h0000)}));
    end
    release_rsp("bp");
    cycle();
    chk("bp.not_queued", 64'({cmd_ready, rsp_valid, per_en}), 64'(3'b100));

    // WAIT_CYC=3 instance: RESLO read two cycles later, bus idle throughout WAIT
    cmd_mode = 2'b00;
    cmd_clr  = 1'b0;
    cmd_op1  = 16'h0101;
    cmd_op2  = 16'h0202;
    chk("w3.cmd_ready", 64'(cmd_ready3), 64'(1'b1));
    cmd_valid3 = 1'b1;
    cycle();
    cmd_valid3 = 1'b0;
    chk("w3.wr_op1", 64'({per_en3, per_we3, per_addr3, per_din3}), 64'({1'b1, 2'b11, 14'h098, 16'h0101}));
    cycle();
    chk("w3.wr_op2", 64'({per_en3, per_we3, per_addr3, per_din3}), 64'({1'b1, 2'b11, 14'h09C, 16'h0202}));
    cycle();
    for (int i = 0; i < 3; i++) begin
      chk("w3.wait", 64'({rsp_valid3, per_en3, per_we3, per_addr3}), 64'(0));
      cycle();
    end
    chk("w3.rd_lo", 64'({rsp_valid3, per_en3, per_we3, per_addr3}), 64'({1'b0, 1'b1, 2'b00, 14'h09D}));
    cycle();
    chk("w3.rd_hi", 64'({rsp_valid3, per_en3, per_we3, per_addr3}), 64'({1'b0, 1'b1, 2'b00, 14'h09E}));
    cycle();
`ifdef MPY_SEQ_SUMEXT_EN
    chk("w3.rd_ext", 64'({rsp_valid3, per_en3, per_we3, per_addr3}), 64'({1'b0, 1'b1, 2'b00, 14'h09F}));
    cycle();
`endif
    chk("w3.resp", 64'({cmd_ready3, rsp_valid3, per_en3}), 64'(3'b010));
    chk("w3.data", 64'({rsp_lo3, rsp_hi3, rsp_sumext3}),
        64'({16'h809D, 16'h809E, (EXT_ON ? 16'h809F : 16'h0000)}));
    rsp_ready3 = 1'b1;
    cycle();
    rsp_ready3 = 1'b0;
    chk("w3.release", 64'({cmd_ready3, rsp_valid3}), 64'(2'b10));

    // Reset asserted while the OP2 write is on the bus
    send(2'b00, 1'b0, 16'h7777, 16'h1111);
    cycle();
    chk("rst_mid.wr_op2", 64'({per_en, per_we, per_addr, per_din}), 64'({1'b1, 2'b11, 14'h09C, 16'h1111}));
    puc_rst = 1'b1;
    cycle();
    chk("rst_mid.ctrl", 64'({per_en, rsp_valid, cmd_ready}), 64'(3'b001));
    chk("rst_mid.bus", 64'({per_en, per_we, per_addr, per_din}), 64'(0));
    puc_rst = 1'b0;
    cycle();
    txn("mpy35", 2'b00, 1'b0, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 16'h0000);
    release_rsp("mpy35");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
